// File: rtl/pipelined_conditional_sum_adder.sv
// Two-stage conditional-sum adder with valid/ready flow control on both sides.
// Define CSA_OVERFLOW_EN to add the registered signed-overflow output.
module pipelined_conditional_sum_adder #(
    parameter int WIDTH       = 32,
    parameter int BLOCK_WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out
`ifdef CSA_OVERFLOW_EN
    ,
    output logic             overflow
`endif
);

    generate
        if (WIDTH < 1 || BLOCK_WIDTH < 1 || (WIDTH % BLOCK_WIDTH) != 0) begin : g_bad_cfg
            $error("WIDTH must be >= 1 and a multiple of BLOCK_WIDTH");
        end
    endgenerate

    localparam int NB = WIDTH / BLOCK_WIDTH;
    localparam logic [BLOCK_WIDTH:0] ONE = {{BLOCK_WIDTH{1'b0}}, 1'b1};

    logic [NB-1:0][BLOCK_WIDTH:0] s0_d;
    logic [NB-1:0][BLOCK_WIDTH:0] s1_d;
    logic [NB-1:0][BLOCK_WIDTH:0] s0_q;
    logic [NB-1:0][BLOCK_WIDTH:0] s1_q;
    logic                         cin_q;
    logic                         s1_valid;
    logic                         adv1;
    logic                         adv2;
    logic [NB:0]                  c;
    logic [WIDTH-1:0]             sum_d;

    assign adv2     = ~out_valid | out_ready;
    assign adv1     = ~s1_valid | adv2;
    assign in_ready = adv1;

    // Each block speculates on both possible carry-ins.
    always_comb begin
        s0_d = '0;
        s1_d = '0;
        for (int i = 0; i < NB; i++) begin
            s0_d[i] = {1'b0, a[i*BLOCK_WIDTH +: BLOCK_WIDTH]}
                    + {1'b0, b[i*BLOCK_WIDTH +: BLOCK_WIDTH]};
            s1_d[i] = {1'b0, a[i*BLOCK_WIDTH +: BLOCK_WIDTH]}
                    + {1'b0, b[i*BLOCK_WIDTH +: BLOCK_WIDTH]}
                    + ONE;
        end
    end

    always_comb begin
        c     = '0;
        sum_d = '0;
        c[0]  = cin_q;
        for (int i = 0; i < NB; i++) begin
            sum_d[i*BLOCK_WIDTH +: BLOCK_WIDTH] = c[i] ? s1_q[i][BLOCK_WIDTH-1:0]
                                                       : s0_q[i][BLOCK_WIDTH-1:0];
            c[i+1] = c[i] ? s1_q[i][BLOCK_WIDTH] : s0_q[i][BLOCK_WIDTH];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s0_q     <= '0;
            s1_q     <= '0;
            cin_q    <= 1'b0;
        end else if (adv1) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s0_q  <= s0_d;
                s1_q  <= s1_d;
                cin_q <= carry_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            carry_out <= 1'b0;
        end else if (adv2) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum       <= sum_d;
                carry_out <= c[NB];
            end
        end
    end

`ifdef CSA_OVERFLOW_EN
    // Carry into the MSB is recovered from the chosen sum bit and a^b at the MSB.
    logic msb_x_q;
    logic ovf_d;

    assign ovf_d = c[NB] ^ sum_d[WIDTH-1] ^ msb_x_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            msb_x_q <= 1'b0;
        end else if (adv1 && in_valid) begin
            msb_x_q <= a[WIDTH-1] ^ b[WIDTH-1];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overflow <= 1'b0;
        end else if (adv2 && s1_valid) begin
            overflow <= ovf_d;
        end
    end
`endif

endmodule

// File: tb/tb_pipelined_conditional_sum_adder.sv
// Bench for pipelined_conditional_sum_adder: vector table, handshake corners,
// random streaming and an 8-bit sweep against an arithmetic reference.
module tb_pipelined_conditional_sum_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        carry_in;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    logic       in_valid8;
    logic       in_ready8a;
    logic       in_ready8b;
    logic [7:0] a8;
    logic [7:0] b8;
    logic       c8;
    logic       out_valid8a;
    logic       out_valid8b;
    logic [7:0] sum8a;
    logic [7:0] sum8b;
    logic       co8a;
    logic       co8b;
    logic       ovf8a;
    logic       ovf8b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pipelined_conditional_sum_adder #(.WIDTH(16), .BLOCK_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .carry_in(carry_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .carry_out(carry_out)
`ifdef CSA_OVERFLOW_EN
        , .overflow(overflow)
`endif
    );

    pipelined_conditional_sum_adder #(.WIDTH(8), .BLOCK_WIDTH(2)) dut8a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8a),
        .a(a8), .b(b8), .carry_in(c8),
        .out_valid(out_valid8a), .out_ready(1'b1),
        .sum(sum8a), .carry_out(co8a)
`ifdef CSA_OVERFLOW_EN
        , .overflow(ovf8a)
`endif
    );

    pipelined_conditional_sum_adder #(.WIDTH(8), .BLOCK_WIDTH(8)) dut8b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8b),
        .a(a8), .b(b8), .carry_in(c8),
        .out_valid(out_valid8b), .out_ready(1'b1),
        .sum(sum8b), .carry_out(co8b)
`ifdef CSA_OVERFLOW_EN
        , .overflow(ovf8b)
`endif
    );

`ifndef CSA_OVERFLOW_EN
    assign overflow = 1'b0;
    assign ovf8a    = 1'b0;
    assign ovf8b    = 1'b0;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [15:0] s;
        logic        co;
        logic        ov;
    } res_t;

    res_t q[$];
    res_t q8[$];

    // Reference: plain integer addition, pipe viewed as a 2-deep in-order FIFO.
    always @(negedge clk) begin
        res_t        e;
        logic [16:0] full;
        if (!rst_n) begin
            q.delete();
        end else begin
            chk("ready_cap", in_ready, (q.size() < 2) || out_ready);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("sb_extra_out", out_valid, 0);
                end else begin
                    e = q.pop_front();
                    chk("sb_sum", sum, e.s);
                    chk("sb_cout", carry_out, e.co);
`ifdef CSA_OVERFLOW_EN
                    chk("sb_ovf", overflow, e.ov);
`endif
                end
            end
            if (in_valid && in_ready) begin
                full = {1'b0, a} + {1'b0, b} + 17'(carry_in);
                e.s  = full[15:0];
                e.co = full[16];
                e.ov = (a[15] == b[15]) && (full[15] != a[15]);
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        res_t       e;
        logic [8:0] full;
        if (!rst_n) begin
            q8.delete();
        end else begin
            if (out_valid8a || out_valid8b) begin
                chk("w8_valid_pair", out_valid8b, out_valid8a);
                if (q8.size() == 0) begin
                    chk("w8_extra_out", 1, 0);
                end else begin
                    e = q8.pop_front();
                    chk("w8_sum_b2", sum8a, e.s);
                    chk("w8_cout_b2", co8a, e.co);
                    chk("w8_sum_b8", sum8b, e.s);
                    chk("w8_cout_b8", co8b, e.co);
`ifdef CSA_OVERFLOW_EN
                    chk("w8_ovf_b2", ovf8a, e.ov);
                    chk("w8_ovf_b8", ovf8b, e.ov);
`endif
                end
            end
            if (in_valid8 && in_ready8a) begin
                full = {1'b0, a8} + {1'b0, b8} + 9'(c8);
                e.s  = {8'h00, full[7:0]};
                e.co = full[8];
                e.ov = (a8[7] == b8[7]) && (full[7] != a8[7]);
                q8.push_back(e);
            end
        end
    end

    // Caller is at posedge+1 with an empty pipe and out_ready=1.
    task automatic one_shot(input logic [15:0] x, input logic [15:0] y, input logic ci,
                            input logic [15:0] es, input logic eco, input logic eov,
                            input string nm);
        a        = x;
        b        = y;
        carry_in = ci;
        in_valid = 1'b1;
        @(negedge clk);
        chk({nm, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk({nm, "_not_yet"}, out_valid, 0);
        @(posedge clk);
        @(negedge clk);
        chk({nm, "_out_valid"}, out_valid, 1);
        chk({nm, "_sum"}, sum, es);
        chk({nm, "_cout"}, carry_out, eco);
`ifdef CSA_OVERFLOW_EN
        chk({nm, "_ovf"}, overflow, eov);
`else
        if (eov === 1'bx) chk({nm, "_ovf_x"}, eov, 0);
`endif
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        ci;
        logic [15:0] s;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t        tbl[8];
    logic [10:0] hist;
    logic [15:0] held;

    initial begin
        tbl[0] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
        tbl[1] = '{16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0};
        tbl[2] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
        tbl[3] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
        tbl[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
        tbl[6] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1, 1'b0};
        tbl[7] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        a         = '0;
        b         = '0;
        carry_in  = 1'b0;
        in_valid8 = 1'b0;
        a8        = '0;
        b8        = '0;
        c8        = 1'b0;
        #3;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", carry_out, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) begin
            one_shot(tbl[i].a, tbl[i].b, tbl[i].ci, tbl[i].s, tbl[i].co, tbl[i].ov,
                     $sformatf("vec%0d", i));
        end

        // Back-to-back stream, results expected on 8 consecutive cycles.
        hist = '0;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin
                a        = 16'h1234;
                b        = 16'h4321;
                carry_in = 1'b1;
            end else begin
                a        = 16'($urandom);
                b        = 16'($urandom);
                carry_in = 1'($urandom);
            end
            in_valid = 1'b1;
            @(negedge clk);
            hist[i] = out_valid;
            chk("b2b_in_ready", in_ready, 1);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        for (int j = 8; j < 11; j++) begin
            @(negedge clk);
            hist[j] = out_valid;
        end
        chk("b2b_pattern", hist, 11'b01111111100);
        @(posedge clk);
        #1;

        // Backpressure: two accepted, third blocked, output frozen.
        out_ready = 1'b0;
        a = 16'h0102; b = 16'h0304; carry_in = 1'b1; in_valid = 1'b1;
        @(negedge clk);
        chk("bp_acc0", in_ready, 1);
        @(posedge clk);
        #1 a = 16'hFFF0; b = 16'h0020; carry_in = 1'b0;
        @(negedge clk);
        chk("bp_acc1", in_ready, 1);
        @(posedge clk);
        #1 a = 16'h4000; b = 16'h4000; carry_in = 1'b0;
        held = 16'h0407;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("bp_in_ready_low", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            chk("bp_sum_held", sum, held);
            chk("bp_cout_held", carry_out, 0);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(negedge clk);
        chk("bp_reopen", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("bp_drained", q.size(), 0);

        // Reset with both stages holding data.
        out_ready = 1'b0;
        a = 16'h1111; b = 16'h2222; carry_in = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1 a = 16'h0005; b = 16'h0006;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("mid_pre_valid", out_valid, 1);
        chk("mid_pre_sum", sum, 16'h3333);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_sum", sum, 0);
        chk("mid_rst_cout", carry_out, 0);
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        one_shot(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0, "post_rst");

        // Random handshakes on both sides.
        for (int i = 0; i < 600; i++) begin
            in_valid  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            a         = 16'($urandom);
            b         = 16'($urandom);
            carry_in  = 1'($urandom);
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("rand_drained", q.size(), 0);

        // 8-bit sweep of every a,b pair, multi-block and single-block builds.
        for (int i = 0; i < 65536; i++) begin
            a8        = 8'(i);
            b8        = 8'(i >> 8);
            c8        = 1'($urandom);
            in_valid8 = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid8 = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("w8_drained", q8.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
